game_turn_controller: RTL and testbench
=======================================

// Module: game_turn_controller
// PURPOSE
//   Central sequencer for the two-player code-breaking game. Shares one switch bank and
//   one debounced button between both players: secret entry, alternating guesses,
//   win/draw detection and win-banner hold. Drives the external compare_codes block via
//   guess_o/opp_secret_o and consumes its exact-match count. Top-level display/LED
//   logic keys off state_o, active_o and win_o.
// PARAMETERS
//   CODE_W           16           code width in bits (DIGITS x 4-bit hex digits)
//   DIGITS           4            digits per code; full match when right_cnt == DIGITS
//   MAX_ROUNDS       10           rounds (P1 guess + P2 guess) before a draw, 1..15
//   WIN_HOLD_CYCLES  500000000    clk cycles the WIN banner holds before DISP
// PORTS
//   clk           in   1       system clock, rising edge
//   rst           in   1       asynchronous, active-low reset
//   btn_pulse     in   1       debounced press, exactly one cycle high per press
//   switches      in   CODE_W  live switch bank
//   right_cnt     in   3       compare_codes exact-match count for guess_o vs opp_secret_o
//   secret1_o     out  CODE_W  P1 secret (guessed by P2)
//   secret2_o     out  CODE_W  P2 secret (guessed by P1)
//   guess_o       out  CODE_W  last latched guess
//   opp_secret_o  out  CODE_W  secret2_o when active_o==0, else secret1_o (combinational)
//   active_o      out  1       player to move: 0=P1, 1=P2
//   state_o       out  3       encoded FSM state (below)
//   round_o       out  4       current round, 0 before play, 1..MAX_ROUNDS
//   win_o         out  2       00 none, 01 P1 won, 10 P2 won, 11 draw
//   leds_o        out  CODE_W  LED mirror
// BEHAVIOUR
//   Reset (rst==0, async): state P1_SET; all registered outputs 0; hold timer 0.
//     Async assert aborts any state, incl. mid-WIN-hold; release resumes on next edge.
//   States: P1_SET=0, P2_SET=1, GUESS=2, CHECK=3, WIN=4, DISP=5; 6,7 -> P1_SET next clk.
//   P1_SET: btn_pulse -> secret1_o<=switches; -> P2_SET.
//   P2_SET: btn_pulse -> secret2_o<=switches, active_o<=0, round_o<=1; -> GUESS.
//   GUESS:  btn_pulse -> guess_o<=switches; -> CHECK. right_cnt sampled in CHECK (1 cycle
//     after latch) so external compare has a full cycle; no combinational path to input.
//   CHECK (exactly 1 cycle, priority order):
//     1. right_cnt==DIGITS -> win_o<=active_o?10:01; -> WIN.
//     2. else active_o==1 && round_o==MAX_ROUNDS -> win_o<=11; -> WIN.
//     3. else active_o<=~active_o; round_o+=1 when active_o was 1; -> GUESS.
//   WIN: timer counts 0..WIN_HOLD_CYCLES-1, -> DISP on terminal count, timer cleared.
//   DISP: hold all values; btn_pulse -> clear secrets, guess, round, win, active; -> P1_SET.
//   btn_pulse ignored in CHECK and WIN (no queuing; press in final WIN cycle is lost).
//   Press on same cycle as state entry is acted on in the new state only next press.
//   leds_o: switches in P1_SET/P2_SET/GUESS; guess_o in CHECK/WIN/DISP (registered, 1-cycle lag).
//   Win in P1's turn of round MAX_ROUNDS beats draw; P1 win ends game before P2 guesses.
//   right_cnt > DIGITS treated as no-match (rule 2/3).
// TESTING
//   1 Reset: rst=0 mid-GUESS -> state_o=0, round_o=0, win_o=0, secrets 0 same cycle.
//   2 Setup: presses with switches=16'h1234, 16'h5678, then guess 16'h5678 with
//     right_cnt=4 -> secret1_o=1234, secret2_o=5678, CHECK then WIN, win_o=01.
//   3 Alternation: right_cnt=1 on four guesses -> active_o 0,1,0,1,0; round_o 1,1,2,2,3.
//   4 Draw: MAX_ROUNDS=2, no matches -> after 4th guess win_o=11, state_o=4.
//   5 Hold: WIN_HOLD_CYCLES=8 -> DISP exactly 8 cycles after WIN entry; press during WIN
//     ignored; press in DISP -> P1_SET with all fields cleared.
//   6 P2 win: P1 misses, P2 guess right_cnt=4 -> win_o=10, active_o stays 1.

Source files
------------

// File: rtl/game_turn_controller.sv
// game_turn_controller
//   Central sequencer for the two-player code-breaking game. Both players share one switch
//   bank and one debounced button. The block handles secret entry, alternating guesses,
//   win/draw detection and a timed win-banner hold before the final display.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   btn_pulse     debounced press, one cycle high per press
//   switches      live switch bank
//   right_cnt     exact-match count from the external comparator (guess_o vs opp_secret_o)
//   secret1_o     P1 secret (guessed by P2)
//   secret2_o     P2 secret (guessed by P1)
//   guess_o       last latched guess
//   opp_secret_o  secret of the player not on the move (combinational)
//   active_o      player to move: 0=P1, 1=P2
//   state_o       encoded state: 0 P1_SET, 1 P2_SET, 2 GUESS, 3 CHECK, 4 WIN, 5 DISP
//   round_o       current round, 0 before play, 1..MAX_ROUNDS
//   win_o         00 none, 01 P1 won, 10 P2 won, 11 draw
//   leds_o        registered LED mirror: switches while entering, guess afterwards
module game_turn_controller #(
  parameter int unsigned CODE_W          = 16,
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned MAX_ROUNDS      = 10,
  parameter int unsigned WIN_HOLD_CYCLES = 500000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_pulse,
  input  logic [CODE_W-1:0] switches,
  input  logic [2:0]        right_cnt,
  output logic [CODE_W-1:0] secret1_o,
  output logic [CODE_W-1:0] secret2_o,
  output logic [CODE_W-1:0] guess_o,
  output logic [CODE_W-1:0] opp_secret_o,
  output logic              active_o,
  output logic [2:0]        state_o,
  output logic [3:0]        round_o,
  output logic [1:0]        win_o,
  output logic [CODE_W-1:0] leds_o
);

  localparam int unsigned TimerW = (WIN_HOLD_CYCLES > 1) ? $clog2(WIN_HOLD_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(WIN_HOLD_CYCLES - 1);
  localparam logic [3:0]        LastRound = 4'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    StP1Set = 3'd0,
    StP2Set = 3'd1,
    StGuess = 3'd2,
    StCheck = 3'd3,
    StWin   = 3'd4,
    StDisp  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   secret1_q, secret1_d;
  logic [CODE_W-1:0]   secret2_q, secret2_d;
  logic [CODE_W-1:0]   guess_q, guess_d;
  logic [CODE_W-1:0]   leds_q, leds_d;
  logic                active_q, active_d;
  logic [3:0]          round_q, round_d;
  logic [1:0]          win_q, win_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                full_match;

  // Counts above DIGITS are not a full match and fall through to the draw/alternate rules.
  assign full_match = (32'(right_cnt) == DIGITS);

  always_comb begin
    state_d   = state_q;
    secret1_d = secret1_q;
    secret2_d = secret2_q;
    guess_d   = guess_q;
    active_d  = active_q;
    round_d   = round_q;
    win_d     = win_q;
    timer_d   = '0;

    case (state_q)
      StP1Set: begin
        if (btn_pulse) begin
          secret1_d = switches;
          state_d   = StP2Set;
        end
      end
      StP2Set: begin
        if (btn_pulse) begin
          secret2_d = switches;
          active_d  = 1'b0;
          round_d   = 4'd1;
          state_d   = StGuess;
        end
      end
      StGuess: begin
        if (btn_pulse) begin
          guess_d = switches;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // right_cnt is only looked at here, a full cycle after the guess was latched.
        if (full_match) begin
          win_d   = active_q ? 2'b10 : 2'b01;
          state_d = StWin;
        end else if (active_q && (round_q == LastRound)) begin
          win_d   = 2'b11;
          state_d = StWin;
        end else begin
          active_d = ~active_q;
          if (active_q) begin
            round_d = round_q + 4'd1;
          end
          state_d = StGuess;
        end
      end
      StWin: begin
        if (timer_q == TimerLast) begin
          state_d = StDisp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDisp: begin
        if (btn_pulse) begin
          secret1_d = '0;
          secret2_d = '0;
          guess_d   = '0;
          active_d  = 1'b0;
          round_d   = '0;
          win_d     = '0;
          state_d   = StP1Set;
        end
      end
      default: begin
        // Unused encodings recover to the start of a game.
        state_d = StP1Set;
      end
    endcase
  end

  always_comb begin
    leds_d = guess_q;
    if ((state_q == StP1Set) || (state_q == StP2Set) || (state_q == StGuess)) begin
      leds_d = switches;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StP1Set;
      secret1_q <= '0;
      secret2_q <= '0;
      guess_q   <= '0;
      leds_q    <= '0;
      active_q  <= 1'b0;
      round_q   <= '0;
      win_q     <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      secret1_q <= secret1_d;
      secret2_q <= secret2_d;
      guess_q   <= guess_d;
      leds_q    <= leds_d;
      active_q  <= active_d;
      round_q   <= round_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
    end
  end

  assign secret1_o    = secret1_q;
  assign secret2_o    = secret2_q;
  assign guess_o      = guess_q;
  assign opp_secret_o = active_q ? secret1_q : secret2_q;
  assign active_o     = active_q;
  assign state_o      = state_q;
  assign round_o      = round_q;
  assign win_o        = win_q;
  assign leds_o       = leds_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller with MAX_ROUNDS=3 and an 8-cycle win hold.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_game_turn_controller;

  localparam int unsigned CodeW = 16;

  logic             clk;
  logic             rst;
  logic             btn_pulse;
  logic [CodeW-1:0] switches;
  logic [2:0]       right_cnt;
  logic [CodeW-1:0] secret1_o;
  logic [CodeW-1:0] secret2_o;
  logic [CodeW-1:0] guess_o;
  logic [CodeW-1:0] opp_secret_o;
  logic             active_o;
  logic [2:0]       state_o;
  logic [3:0]       round_o;
  logic [1:0]       win_o;
  logic [CodeW-1:0] leds_o;

  int total = 0;
  int bad   = 0;

  game_turn_controller #(
    .CODE_W          (CodeW),
    .DIGITS          (4),
    .MAX_ROUNDS      (3),
    .WIN_HOLD_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_pulse    (btn_pulse),
    .switches     (switches),
    .right_cnt    (right_cnt),
    .secret1_o    (secret1_o),
    .secret2_o    (secret2_o),
    .guess_o      (guess_o),
    .opp_secret_o (opp_secret_o),
    .active_o     (active_o),
    .state_o      (state_o),
    .round_o      (round_o),
    .win_o        (win_o),
    .leds_o       (leds_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle press; returns on the falling edge after the edge that saw it.
  task automatic press(input logic [CodeW-1:0] sw);
    switches  = sw;
    btn_pulse = 1'b1;
    step();
    btn_pulse = 1'b0;
  endtask

  // Guess then let CHECK resolve; returns in the state after CHECK.
  task automatic guess(input logic [CodeW-1:0] sw, input logic [2:0] rc);
    right_cnt = rc;
    press(sw);
    chk("guess_in_check", 32'(state_o), 32'd3);
    step();
  endtask

  int unsigned exp_act[4] = '{1, 0, 1, 0};
  int unsigned exp_rnd[4] = '{1, 2, 2, 3};

  initial begin
    rst       = 1'b0;
    btn_pulse = 1'b0;
    switches  = '0;
    right_cnt = '0;
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_round", 32'(round_o), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Setup and P1 immediate win.
    switches = 16'hC3C3;
    step();
    chk("leds_follow_sw", 32'(leds_o), 32'hC3C3);
    press(16'h1234);
    chk("p1set_state", 32'(state_o), 32'd1);
    chk("secret1", 32'(secret1_o), 32'h1234);
    press(16'h5678);
    chk("p2set_state", 32'(state_o), 32'd2);
    chk("secret2", 32'(secret2_o), 32'h5678);
    chk("round_start", 32'(round_o), 32'd1);
    chk("active_start", 32'(active_o), 32'd0);
    chk("opp_secret_p1", 32'(opp_secret_o), 32'h5678);
    right_cnt = 3'd4;
    press(16'h5678);
    chk("check_state", 32'(state_o), 32'd3);
    chk("guess_latched", 32'(guess_o), 32'h5678);
    step();
    chk("win_state", 32'(state_o), 32'd4);
    chk("win_p1", 32'(win_o), 32'h1);

    // Hold: 8 cycles in WIN, press inside WIN ignored.
    step();
    step();
    btn_pulse = 1'b1;
    step();
    btn_pulse = 1'b0;
    step();
    step();
    step();
    step();
    chk("hold_last_win", 32'(state_o), 32'd4);
    step();
    chk("hold_disp", 32'(state_o), 32'd5);
    chk("disp_win_held", 32'(win_o), 32'h1);
    chk("disp_leds_guess", 32'(leds_o), 32'h5678);
    press(16'hFFFF);
    chk("clear_state", 32'(state_o), 32'd0);
    chk("clear_secret1", 32'(secret1_o), 32'h0);
    chk("clear_secret2", 32'(secret2_o), 32'h0);
    chk("clear_guess", 32'(guess_o), 32'h0);
    chk("clear_round", 32'(round_o), 32'd0);
    chk("clear_win", 32'(win_o), 32'd0);

    // Alternation, then draw at round MAX_ROUNDS.
    press(16'hAAAA);
    press(16'hBBBB);
    for (int i = 0; i < 4; i++) begin
      guess(16'(16'h0100 + i), 3'd1);
      chk("alt_active", 32'(active_o), 32'(exp_act[i]));
      chk("alt_round", 32'(round_o), 32'(exp_rnd[i]));
    end
    chk("alt_no_win", 32'(win_o), 32'd0);
    guess(16'h0200, 3'd5);  // over-range count is a miss
    chk("overrange_active", 32'(active_o), 32'd1);
    chk("opp_secret_p2", 32'(opp_secret_o), 32'hAAAA);
    guess(16'h0300, 3'd0);
    chk("draw_state", 32'(state_o), 32'd4);
    chk("draw_win", 32'(win_o), 32'h3);
    for (int i = 0; i < 8; i++) step();
    chk("draw_disp", 32'(state_o), 32'd5);
    press(16'h0000);

    // P2 win.
    press(16'h0001);
    press(16'h0002);
    guess(16'h0003, 3'd2);
    guess(16'h0001, 3'd4);
    chk("p2win_state", 32'(state_o), 32'd4);
    chk("p2win_win", 32'(win_o), 32'h2);
    chk("p2win_active", 32'(active_o), 32'd1);
    for (int i = 0; i < 8; i++) step();
    press(16'h0000);

    // Async reset mid-GUESS.
    press(16'h1111);
    press(16'h2222);
    chk("pre_rst_state", 32'(state_o), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_round", 32'(round_o), 32'd0);
    chk("async_secret1", 32'(secret1_o), 32'h0);
    chk("async_secret2", 32'(secret2_o), 32'h0);
    chk("async_win", 32'(win_o), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_state", 32'(state_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
